// File: rtl/logic_unit_serial.sv
// Serial bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per clock; result valid NSLICE cycles after accept.
// Backpressure: out_ready low holds DONE with result/zero frozen; in_ready is high only in IDLE.
module logic_unit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
      $error("logic_unit_serial: SLICE must evenly divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic             last;
  logic             accept;

  assign last = (cnt == CW'(NSLICE - 1));

  // Only one SLICE-wide gate exists; operands are muxed down to it by cnt.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_AND:  r_sl = a_sl & b_sl;
      OP_OR:   r_sl = a_sl | b_sl;
      OP_XOR:  r_sl = a_sl ^ b_sl;
      default: r_sl = ~(a_sl | b_sl);
    endcase
  end

  // Full next result, so zero can be taken from it on the final slice.
  always_comb begin
    res_nxt = result;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        res_nxt[i*SLICE +: SLICE] = r_sl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= op_t'(op);
      cnt    <= '0;
      result <= '0;
    end else if (state == BUSY) begin
      result <= res_nxt;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        zero <= ~|res_nxt;
      end
    end
  end

endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Parametrised, multi-cycle bitwise logic unit for the multi-cycle datapath.
- Generalises the fixed 16-bit single-gate OR stage in three ways: WIDTH is a parameter, AND/OR/XOR/NOR are selectable, and the operands are processed SLICE bits per clock.
- Operands are taken with a valid/ready handshake and the result is returned the same way, together with a zero flag.
- Sits beside the ALU. The multi-cycle control FSM uses it to trade area for latency on logical ops.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle. Must divide WIDTH exactly; otherwise elaboration fails (generate-time error).
- NSLICE, WIDTH/SLICE, derived (localparam). Number of BUSY cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept an operation.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  high when result == 0. Qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; slice counter = 0; operand/op registers = 0.
  - result = 0, zero = 0, out_valid = 0, in_ready = 1 (in_ready is a decode of IDLE).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch a, b, op; clear result register and counter; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle computes bits [cnt*SLICE +: SLICE] of op(a_reg, b_reg), writes them into the result register, and increments cnt.
  - When cnt == NSLICE-1, the last slice is written and the state goes to DONE.
  - Live a/b/op/in_valid are ignored.
- DONE:
  - out_valid = 1; result and zero are held stable.
  - On out_ready: go to IDLE (out_valid drops the next cycle).
  - in_ready = 0, so a new accept never overlaps DONE.
- Latency:
  - Accept edge at cycle k; out_valid is high from cycle k+NSLICE (default 4).
  - Minimum issue interval is NSLICE+2 cycles: accept, NSLICE BUSY, DONE handshake, IDLE.
- zero: registered, computed from the full result on the BUSY→DONE edge.
- NOR: per slice ~(a|b), confined to the slice (no bleed outside WIDTH).
- SLICE == WIDTH: exactly one BUSY cycle, latency 1.
- Backpressure: out_ready low holds DONE indefinitely with no change to outputs.
- out_ready high outside DONE: ignored.
- Reset mid-operation: the operation is aborted and no out_valid is produced; behaviour after rst_n rises is identical to power-up.
- in_valid asserted while not IDLE: not accepted, no side effects. The producer must hold it until in_ready.

Test Plan:
1. Defaults (WIDTH=16, SLICE=4): op=01, a=0x00F0, b=0x0F01 -> result=0x0FF1, zero=0, out_valid exactly 4 cycles after the accept edge.
2. op=11 (NOR), a=0xFFFF, b=0x0000 -> result=0x0000, zero=1; then op=00, a=0xF0F0, b=0x0FF0 -> result=0x00F0, zero=0.
3. op=10, a=0xA5A5, b=0xFFFF; drive a=0x0000 and in_valid=1 during BUSY -> result=0x5A5A, in_ready=0 throughout, second request not taken until IDLE.
4. out_ready held low 5 cycles in DONE -> result/zero/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
5. rst_n pulsed low during the 2nd BUSY cycle of op=01 a=0x1234 b=0x4321 -> out_valid never asserted, result=0, in_ready=1 immediately; next op completes normally.
6. Instance WIDTH=16, SLICE=16: op=00, a=0x1234, b=0x00FF -> result=0x0034, out_valid 1 cycle after accept; instance WIDTH=32, SLICE=8: op=01 a=0x80000000 b=0x00000001 -> 0x80000001 after 4 cycles.
